// File: rtl/tlul_sram_responder.sv
// TL-UL device-side SRAM responder: accepts A-channel Get/Put, drives a 1-cycle SRAM,
// and returns D-channel responses in order through a response FIFO.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tlul_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tlul_d2h_t;

endpackage

module tlul_sram_responder #(
  parameter int SramAw      = 12,
  parameter int SramDw      = 32,
  parameter int Outstanding = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  tlul_pkg::tlul_h2d_t tl_i,
  output tlul_pkg::tlul_d2h_t tl_o,
  output logic                req_o,
  output logic                we_o,
  output logic [SramAw-1:0]   addr_o,
  output logic [SramDw-1:0]   wdata_o,
  output logic [SramDw-1:0]   wmask_o,
  input  logic [SramDw-1:0]   rdata_i
);
  import tlul_pkg::*;

  localparam int PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
  localparam int CntW = $clog2(Outstanding + 1);

  typedef struct packed {
    tl_d_op_e          opcode;
    logic [1:0]        size;
    logic [7:0]        source;
    logic              error;
    logic [SramDw-1:0] data;
  } rsp_t;

  logic              pipe_vld_q, pipe_get_q, pipe_err_q;
  logic [1:0]        pipe_size_q;
  logic [7:0]        pipe_src_q;

  rsp_t              fifo_q [Outstanding];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   fcnt_q;

  logic [CntW:0]     count;
  logic              a_ready, accept, d_valid, push, pop;
  logic              is_get, is_put, is_full, op_ok, misalign, a_err;
  logic [3:0]        lanes;
  rsp_t              push_rsp;
  logic              unused_tl;

  assign unused_tl = ^tl_i;

  assign count   = (CntW+1)'(fcnt_q) + (CntW+1)'(pipe_vld_q);
  assign a_ready = !rst_i && (count < (CntW+1)'(Outstanding));
  assign accept  = tl_i.a_valid && a_ready;
  assign d_valid = !rst_i && (fcnt_q != '0);
  assign pop     = d_valid && tl_i.d_ready;
  assign push    = pipe_vld_q;

  // Byte lanes a well-formed request of this size/offset may touch.
  always_comb begin
    is_get   = (tl_i.a_opcode == Get);
    is_full  = (tl_i.a_opcode == PutFullData);
    is_put   = is_full || (tl_i.a_opcode == PutPartialData);
    op_ok    = is_get || is_put;
    lanes    = 4'b1111;
    misalign = 1'b0;
    case (tl_i.a_size)
      2'd0: lanes = 4'b0001 << tl_i.a_address[1:0];
      2'd1: begin
        lanes    = 4'b0011 << tl_i.a_address[1:0];
        misalign = tl_i.a_address[0];
      end
      default: misalign = (tl_i.a_address[1:0] != 2'b00);
    endcase
    a_err = !op_ok || (tl_i.a_size == 2'd3) || misalign
         || (is_put && ((tl_i.a_mask & ~lanes) != 4'b0000))
         || (is_full && (tl_i.a_mask != lanes));
  end

  always_comb begin
    req_o   = accept && !a_err;
    we_o    = req_o && is_put;
    addr_o  = tl_i.a_address[SramAw+1:2];
    wdata_o = tl_i.a_data;
    wmask_o = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      wmask_o[8*i +: 8] = {8{tl_i.a_mask[i]}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_vld_q  <= 1'b0;
      pipe_get_q  <= 1'b0;
      pipe_err_q  <= 1'b0;
      pipe_size_q <= '0;
      pipe_src_q  <= '0;
    end else begin
      pipe_vld_q <= accept;
      if (accept) begin
        pipe_get_q  <= is_get;
        pipe_err_q  <= a_err;
        pipe_size_q <= tl_i.a_size;
        pipe_src_q  <= tl_i.a_source;
      end
    end
  end

  // Read data is only valid in the cycle after the access, so it is captured at push.
  always_comb begin
    push_rsp.opcode = pipe_get_q ? AccessAckData : AccessAck;
    push_rsp.size   = pipe_size_q;
    push_rsp.source = pipe_src_q;
    push_rsp.error  = pipe_err_q;
    if (!pipe_get_q)     push_rsp.data = '0;
    else if (pipe_err_q) push_rsp.data = '1;
    else                 push_rsp.data = rdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= push_rsp;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) wptr_q <= (wptr_q == PtrW'(Outstanding - 1)) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_q <= (rptr_q == PtrW'(Outstanding - 1)) ? '0 : rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  always_comb begin
    tl_o = '0;
    if (!rst_i) begin
      tl_o.a_ready = a_ready;
      tl_o.d_valid = d_valid;
      if (d_valid) begin
        tl_o.d_opcode = fifo_q[rptr_q].opcode;
        tl_o.d_size   = fifo_q[rptr_q].size;
        tl_o.d_source = fifo_q[rptr_q].source;
        tl_o.d_error  = fifo_q[rptr_q].error;
        tl_o.d_data   = fifo_q[rptr_q].data;
      end
    end
  end

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Scoreboard bench for tlul_sram_responder: the driver pushes expected responses
// from a byte-level memory model at accept; a monitor pops and compares on d_valid.
module tb_tlul_sram_responder;
  import tlul_pkg::*;

  localparam int OUT = 3;
  localparam int AW  = 12;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              init_mem = 1'b1;
  tlul_h2d_t         a_req;
  logic              d_rdy;
  tlul_h2d_t         tl_i;
  tlul_d2h_t         tl_o;
  logic              req_o, we_o;
  logic [AW-1:0]     addr_o;
  logic [31:0]       wdata_o, wmask_o, rdata_i;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic        err;
    logic [31:0] data;
    bit          full;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] sram    [4096];
  logic [31:0] ref_mem [4096];
  int          total = 0, bad = 0, cyc = 0, acc_cnt = 0, stalls = 0;
  int          rdy_mode = 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    tl_i = a_req;
    tl_i.d_ready = d_rdy;
  end

  tlul_sram_responder #(.SramAw(AW), .SramDw(32), .Outstanding(OUT)) dut (
    .clk_i(clk), .rst_i(rst_i), .tl_i(tl_i), .tl_o(tl_o),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .wmask_o(wmask_o), .rdata_i(rdata_i)
  );

  // Behavioural single-port SRAM with 1-cycle read latency.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 4096; i++) sram[i] <= 32'(i) * 32'h9E37_79B9;
    end else if (req_o) begin
      if (we_o) sram[addr_o] <= (sram[addr_o] & ~wmask_o) | (wdata_o & wmask_o);
      else      rdata_i <= sram[addr_o];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic bit ref_err(input logic [2:0] op, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [3:0] mask);
    int off = int'(addr % 32'd4);
    int n   = 1 << size;
    logic [3:0] ln = '0;
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b1;
    if (size > 2'd2) return 1'b1;
    if ((int'(addr % 32'd4) % n) != 0) return 1'b1;
    for (int b = 0; b < 4; b++) if (b >= off && b < off + n) ln[b] = 1'b1;
    if (op != 3'd4 && (mask & ~ln) != 4'b0000) return 1'b1;
    if (op == 3'd0 && mask != ln) return 1'b1;
    return 1'b0;
  endfunction

  task automatic on_accept();
    exp_t        e;
    logic [31:0] wm = '0;
    int          w = int'(a_req.a_address[AW+1:2]);
    e.op   = (a_req.a_opcode == 3'd4) ? 3'd1 : 3'd0;
    e.size = a_req.a_size;
    e.src  = a_req.a_source;
    e.err  = ref_err(a_req.a_opcode, a_req.a_size, a_req.a_address, a_req.a_mask);
    e.full = (a_req.a_opcode == 3'd0 || a_req.a_opcode == 3'd1 || a_req.a_opcode == 3'd4);
    e.cyc  = cyc;
    for (int b = 0; b < 4; b++) if (a_req.a_mask[b]) wm[8*b +: 8] = 8'hFF;
    chk("req_o", 64'(req_o), 64'(!e.err));
    if (e.err) begin
      e.data = (e.op == 3'd1) ? 32'hFFFF_FFFF : 32'h0;
    end else begin
      chk("addr_o", 64'(addr_o), 64'(w));
      chk("we_o", 64'(we_o), 64'(e.op == 3'd0));
      if (e.op == 3'd0) begin
        chk("wdata_o", 64'(wdata_o), 64'(a_req.a_data));
        chk("wmask_o", 64'(wmask_o), 64'(wm));
        for (int b = 0; b < 4; b++)
          if (a_req.a_mask[b]) ref_mem[w][8*b +: 8] = a_req.a_data[8*b +: 8];
        e.data = 32'h0;
      end else begin
        e.data = ref_mem[w];
      end
    end
    q.push_back(e);
    acc_cnt++;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
    int waitc = 0;
    bit done  = 1'b0;
    a_req.a_valid   = 1'b1;
    a_req.a_opcode  = op;
    a_req.a_size    = sz;
    a_req.a_address = addr;
    a_req.a_mask    = mask;
    a_req.a_data    = data;
    a_req.a_source  = src;
    while (!done) begin
      @(negedge clk); #1;
      if (tl_o.a_ready) begin
        on_accept();
        done = 1'b1;
      end else begin
        stalls++;
        waitc++;
        if (waitc > 200) begin
          chk("accept_timeout", 64'(waitc), 64'd0);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    a_req.a_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_random();
    logic [2:0]  op;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [3:0]  mask, ln;
    logic [2:0]  ops[3] = '{3'd0, 3'd1, 3'd4};
    if ($urandom_range(0, 9) < 7) begin
      op   = ops[$urandom_range(0, 2)];
      sz   = 2'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, 15)) * 4;
      if (sz == 2'd0) addr += 32'($urandom_range(0, 3));
      if (sz == 2'd1) addr += 32'($urandom_range(0, 1)) * 2;
      ln   = (sz == 2'd2) ? 4'hF : (sz == 2'd1) ? (4'b0011 << addr[1:0]) : (4'b0001 << addr[1:0]);
      mask = (op == 3'd0) ? ln : (op == 3'd1) ? (ln & 4'($urandom)) : 4'($urandom);
    end else begin
      op   = 3'($urandom);
      sz   = 2'($urandom);
      addr = 32'($urandom_range(0, 63));
      mask = 4'($urandom);
    end
    send(op, sz, addr, mask, $urandom, 8'($urandom));
    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
  endtask

  initial begin
    d_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      d_rdy = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  end

  // Monitor: reset outputs, a_ready against outstanding depth, head against scoreboard.
  always @(negedge clk) begin
    if (rst_i) begin
      chk("rst_tl_o", 64'(tl_o), 64'd0);
      chk("rst_req_o", 64'(req_o), 64'd0);
      q.delete();
    end else begin
      chk("a_ready", 64'(tl_o.a_ready), 64'(q.size() < OUT));
      if (tl_o.d_valid) begin
        if (q.size() == 0) begin
          chk("stale_d_valid", 64'(tl_o.d_valid), 64'd0);
        end else begin
          chk("d_error", 64'(tl_o.d_error), 64'(q[0].err));
          chk("d_source", 64'(tl_o.d_source), 64'(q[0].src));
          chk("d_size", 64'(tl_o.d_size), 64'(q[0].size));
          chk("d_param_sink", 64'({tl_o.d_param, tl_o.d_sink}), 64'd0);
          chk("latency_min", 64'(cyc - q[0].cyc >= 2), 64'd1);
          if (q[0].full) begin
            chk("d_opcode", 64'(tl_o.d_opcode), 64'(q[0].op));
            chk("d_data", 64'(tl_o.d_data), 64'(q[0].data));
          end
          if (tl_i.d_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int acc0, waitc;
    a_req = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'(i) * 32'h9E37_79B9;
    repeat (3) @(posedge clk);
    #1;
    rst_i    = 1'b0;
    init_mem = 1'b0;
    idle(1);

    // Directed: write/read, partial write, error cases.
    send(3'd0, 2'd2, 32'h10, 4'hF, 32'hDEAD_BEEF, 8'd3);
    send(3'd4, 2'd2, 32'h10, 4'h0, 32'h0, 8'd1);
    send(3'd1, 2'd1, 32'h12, 4'hC, 32'hABCD_0000, 8'd2);
    send(3'd4, 2'd2, 32'h10, 4'h0, 32'h0, 8'd4);
    send(3'd4, 2'd2, 32'h11, 4'hF, 32'h0, 8'd5);
    send(3'd2, 2'd2, 32'h20, 4'hF, 32'h0, 8'd6);
    send(3'd0, 2'd2, 32'h14, 4'h7, 32'h1111_1111, 8'd7);
    send(3'd4, 2'd2, 32'h14, 4'h0, 32'h0, 8'd8);
    idle(6);

    // Streaming Gets with d_ready held high must never stall.
    stalls = 0;
    for (int i = 0; i < 12; i++) send(3'd4, 2'd2, 32'($urandom_range(0, 31)) * 4, 4'hF, 32'h0, 8'(i));
    chk("stream_stalls", 64'(stalls), 64'd0);
    idle(6);

    // Backpressure: four Gets against d_ready=0; only three fit.
    rdy_mode = 0;
    idle(3);
    acc0 = acc_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) send(3'd4, 2'd2, 32'(i) * 4, 4'hF, 32'h0, 8'(8'h40 + i));
      end
      begin
        repeat (10) @(negedge clk);
        #2;
        chk("bp_accepted", 64'(acc_cnt - acc0), 64'd3);
        chk("bp_a_ready", 64'(tl_o.a_ready), 64'd0);
        rdy_mode = 1;
      end
    join
    idle(8);
    chk("bp_all_accepted", 64'(acc_cnt - acc0), 64'd4);

    // Reset with two responses pending must drop them.
    rdy_mode = 0;
    idle(2);
    send(3'd4, 2'd2, 32'h30, 4'hF, 32'h0, 8'h50);
    send(3'd4, 2'd2, 32'h34, 4'hF, 32'h0, 8'h51);
    idle(3);
    chk("pre_rst_d_valid", 64'(tl_o.d_valid), 64'd1);
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    rdy_mode = 1;
    idle(6);
    chk("post_rst_d_valid", 64'(tl_o.d_valid), 64'd0);

    // Randomized traffic with random d_ready.
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) send_random();
    rdy_mode = 1;
    waitc = 0;
    while (q.size() != 0 && waitc < 100) begin
      @(posedge clk);
      waitc++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlul_sram_responder.md
Name: tlul_sram_responder

Overview:
- TL-UL device-side responder that terminates one crossbar device port (e.g. tl_dccm_o / tl_iccm_o) and drives a single-port SRAM macro with fixed 1-cycle read latency.
- Accepts A-channel Get/PutFullData/PutPartialData and issues the SRAM access in the accept cycle.
- Returns AccessAck/AccessAckData on the D channel through a response FIFO that absorbs d_ready backpressure.
- Malformed requests receive a d_error response and never touch the SRAM.

Parameters:
- SramAw, 12, SRAM word-address width; the word index is a_address[SramAw+1:2].
- SramDw, 32, SRAM data width; fixed to the TL-UL data width.
- Outstanding, 3, maximum number of accepted requests not yet popped on the D channel; minimum 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- tl_i  in  tlul_pkg::tlul_h2d_t  A channel and d_ready from the crossbar
- tl_o  out  tlul_pkg::tlul_d2h_t  D channel and a_ready to the crossbar
- req_o  out  1  SRAM access strobe
- we_o  out  1  SRAM write enable
- addr_o  out  SramAw  SRAM word address
- wdata_o  out  SramDw  SRAM write data
- wmask_o  out  SramDw  SRAM bit write mask
- rdata_i  in  SramDw  SRAM read data, valid exactly 1 cycle after a req_o with we_o=0

Behaviour:
- Reset (rst_i sampled high at a clock edge):
  - Clears the pipeline stage, the FIFO and the count.
  - While rst_i is high, a_ready=0, d_valid=0 and req_o=0; all other tl_o fields are 0.
  - Reset mid-operation discards every in-flight response.
- Count: sum of the pipe stage (0 or 1) and the FIFO entries.
  - a_ready = !rst_i && count < Outstanding; there is no same-cycle pop bypass.
  - Accept happens when a_valid && a_ready.
- Error check (combinational on the A channel). A request is an error if any of the following holds:
  - a_opcode is not in {PutFullData=0, PutPartialData=1, Get=4}.
  - a_size > 2.
  - a_address is not aligned to 2^a_size.
  - For Put: a_mask has bits set outside the lanes addressed by a_address[1:0]/a_size.
  - For PutFullData: a_mask does not exactly cover those lanes.
  - a_mask is ignored for Get.
- SRAM access (accept cycle N, non-error only):
  - req_o=1, addr_o = a_address[SramAw+1:2].
  - we_o=1 for Put, with wdata_o=a_data and wmask_o = each a_mask bit replicated 8 times.
  - we_o=0 for Get.
  - An error request raises no req_o.
- Pipe stage, registered at cycle N: opcode class, a_size, a_source, error flag.
- At cycle N+1 the pipe stage pushes one FIFO entry:
  - d_opcode = AccessAckData (1) for Get, AccessAck (0) for Put.
  - d_size = a_size, d_source = a_source, d_sink=0, d_param=0, d_error = error flag.
  - d_data = rdata_i for a good Get, all-ones for an error Get, 0 for any Put.
- d_valid = FIFO not empty; head entry is presented. Response latency is accept plus 2 cycles (d_valid at N+2 minimum).
- Pop on d_valid && d_ready. Push and pop in the same cycle are both honoured, including when the FIFO is full.
- FIFO depth is Outstanding, so it never overflows. Pointers wrap modulo Outstanding.
- Responses are returned strictly in accept order.
- Head fields are held stable while d_valid && !d_ready.
- Count arithmetic: count_next = count + accept - pop. Saturation cannot occur by construction.

Test Plan:
- Write then read: PutFullData addr 0x10, data 0xDEADBEEF, mask 0xF, source 3 -> req_o=1/we_o=1/addr_o=4/wmask_o=0xFFFFFFFF in the accept cycle; AccessAck d_source=3 d_error=0 two cycles later. Get addr 0x10 -> AccessAckData d_data=0xDEADBEEF.
- Partial write: PutPartialData addr 0x12, size 1, mask 0xC, data 0xABCD0000 -> wmask_o=0xFFFF0000. Subsequent Get returns the upper half updated and the lower half preserved.
- Errors:
  - Get addr 0x11 size 2 -> no req_o; AccessAckData d_error=1 d_data=0xFFFFFFFF.
  - a_opcode=2 -> d_error=1.
  - PutFullData size 2 mask 0x7 -> d_error=1, no SRAM write.
- Streaming: continuous Gets with d_ready=1 and Outstanding=3 -> a_ready stays 1, one response per cycle after a 2-cycle fill, in order.
- Backpressure: d_ready=0 with 4 back-to-back Gets -> 3 accepted, a_ready=0 from the third accept onward, d_data stable. Raising d_ready drains the entries in order and the 4th is then accepted.
- Reset mid-operation: rst_i=1 for 1 cycle with 2 responses pending -> d_valid=0 and a_ready=0 during reset; after reset count=0 and no stale response appears.
